// File: rtl/decode_pkg.sv
// Shared types and instruction field positions for the decode stage.
package decode_pkg;

   localparam int INSTR_W = 33;
   localparam int FIELD_W = 5;

   localparam int INM_BIT = 32;
   localparam int TIPO_HI = 31;
   localparam int TIPO_LO = 30;
   localparam int OP_HI   = 29;
   localparam int OP_LO   = 28;
   localparam int RS1_HI  = 27;
   localparam int RS1_LO  = 23;
   localparam int RS2_HI  = 22;
   localparam int RS2_LO  = 18;
   localparam int RD_HI   = 4;
   localparam int RD_LO   = 0;

   // {tipo, op} pair that places rd in the upper register field
   localparam logic [1:0] TIPO_RD_UP = 2'b01;
   localparam logic [1:0] OP_RD_UP   = 2'b00;

   typedef struct packed {
      logic       reg_write;
      logic       alu_src;
      logic       mem_write;
      logic       result_src;
      logic       branch;
      logic [2:0] alu_ctrl;
      logic [1:0] rgb;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_regfile.sv
// Register file, 2 async read / 1 sync write; r0 hardwired to zero.
// DECODE_WB_BYPASS_EN forwards the same-cycle write data to matching reads.
import decode_pkg::*;

module decode_regfile #(
   parameter  int DATA_W   = 18,
   parameter  int NUM_REGS = 32,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata
);

   logic [DATA_W-1:0] r_mem [NUM_REGS];
   logic              w_wr_en;

   assign w_wr_en = i_we && (i_waddr != '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_comb begin
      o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
      o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
`ifdef DECODE_WB_BYPASS_EN
      if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
      if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`endif
   end

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: field decode, register read, load-use stall and D->E pipeline register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data into the register reads.
import decode_pkg::*;

module decode_pipe #(
   parameter  int DATA_W   = 18,
   parameter  int PC_W     = 18,
   parameter  int NUM_REGS = 32,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic               valid_d,
   input  logic [PC_W-1:0]    pc_d,
   input  logic [PC_W-1:0]    pc_plus4_d,
   input  ctrl_t              ctrl_d,
   input  logic [DATA_W-1:0]  imm_ext_d,
   input  logic               reg_write_w,
   input  logic [ADDR_W-1:0]  rd_w,
   input  logic [DATA_W-1:0]  result_w,
   input  logic               flush_e,
   output logic               stall_d,
   output logic               valid_e,
   output ctrl_t              ctrl_e,
   output logic [DATA_W-1:0]  rd1_e,
   output logic [DATA_W-1:0]  rd2_e,
   output logic [DATA_W-1:0]  imm_ext_e,
   output logic [ADDR_W-1:0]  rs1_e,
   output logic [ADDR_W-1:0]  rs2_e,
   output logic [ADDR_W-1:0]  rd_e,
   output logic [PC_W-1:0]    pc_e,
   output logic [PC_W-1:0]    pc_plus4_e
);

   logic [FIELD_W-1:0] w_rs1_f, w_rs2_f, w_rd_f;
   logic [ADDR_W-1:0]  w_rs1, w_rs2, w_rd;
   logic               w_rd_up;
   logic [DATA_W-1:0]  w_rd1, w_rd2;
   logic               w_stall;
   logic               w_bubble;
   logic               w_unused;

   logic               r_valid_e;
   ctrl_t              r_ctrl_e;
   logic [DATA_W-1:0]  r_rd1_e, r_rd2_e, r_imm_ext_e;
   logic [ADDR_W-1:0]  r_rs1_e, r_rs2_e, r_rd_e;
   logic [PC_W-1:0]    r_pc_e, r_pc_plus4_e;

   assign w_rd_up = instr_d[INM_BIT] ||
                    ((instr_d[TIPO_HI:TIPO_LO] == TIPO_RD_UP) && (instr_d[OP_HI:OP_LO] == OP_RD_UP));

   assign w_rs1_f = instr_d[RS1_HI:RS1_LO];
   assign w_rs2_f = instr_d[INM_BIT] ? instr_d[RS2_HI:RS2_LO] : instr_d[RD_HI:RD_LO];
   assign w_rd_f  = w_rd_up ? instr_d[RS2_HI:RS2_LO] : instr_d[RD_HI:RD_LO];

   assign w_rs1 = w_rs1_f[ADDR_W-1:0];
   assign w_rs2 = w_rs2_f[ADDR_W-1:0];
   assign w_rd  = w_rd_f[ADDR_W-1:0];

   assign w_unused = ^{instr_d[RS2_LO-1:RD_HI+1], w_rs1_f, w_rs2_f, w_rd_f};

   decode_regfile #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
   ) u_regfile (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_raddr1 (w_rs1),
      .i_raddr2 (w_rs2),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2),
      .i_we     (reg_write_w),
      .i_waddr  (rd_w),
      .i_wdata  (result_w)
   );

   // Load in E whose destination feeds this D instruction; masked during reset.
   assign w_stall = !rst && valid_d && r_valid_e && r_ctrl_e.result_src && r_ctrl_e.reg_write &&
                    (r_rd_e != '0) && ((r_rd_e == w_rs1) || (r_rd_e == w_rs2));

   // Reset, flush, stall and invalid D all load the same all-zero bubble.
   assign w_bubble = rst || flush_e || w_stall || !valid_d;

   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_valid_e    <= 1'b0;
         r_ctrl_e     <= CTRL_NOP;
         r_rd1_e      <= '0;
         r_rd2_e      <= '0;
         r_imm_ext_e  <= '0;
         r_rs1_e      <= '0;
         r_rs2_e      <= '0;
         r_rd_e       <= '0;
         r_pc_e       <= '0;
         r_pc_plus4_e <= '0;
      end else begin
         r_valid_e    <= 1'b1;
         r_ctrl_e     <= ctrl_d;
         r_rd1_e      <= w_rd1;
         r_rd2_e      <= w_rd2;
         r_imm_ext_e  <= imm_ext_d;
         r_rs1_e      <= w_rs1;
         r_rs2_e      <= w_rs2;
         r_rd_e       <= w_rd;
         r_pc_e       <= pc_d;
         r_pc_plus4_e <= pc_plus4_d;
      end
   end

   assign stall_d    = w_stall;
   assign valid_e    = r_valid_e;
   assign ctrl_e     = r_ctrl_e;
   assign rd1_e      = r_rd1_e;
   assign rd2_e      = r_rd2_e;
   assign imm_ext_e  = r_imm_ext_e;
   assign rs1_e      = r_rs1_e;
   assign rs2_e      = r_rs2_e;
   assign rd_e       = r_rd_e;
   assign pc_e       = r_pc_e;
   assign pc_plus4_e = r_pc_plus4_e;

endmodule

// File: tb/tb_decode_pipe.sv
// Self-checking bench for decode_pipe: directed scenarios plus randomized traffic vs a reference model.
module tb_decode_pipe;
   import decode_pkg::*;

   localparam int DW = 18;
   localparam int PW = 18;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int EW = 1 + $bits(ctrl_t) + 3*DW + 3*AW + 2*PW;

   logic          clk = 1'b0;
   logic          rst;
   logic [32:0]   instr_d;
   logic          valid_d;
   logic [PW-1:0] pc_d, pc_plus4_d;
   ctrl_t         ctrl_d;
   logic [DW-1:0] imm_ext_d;
   logic          reg_write_w;
   logic [AW-1:0] rd_w;
   logic [DW-1:0] result_w;
   logic          flush_e;
   logic          stall_d;
   logic          valid_e;
   ctrl_t         ctrl_e;
   logic [DW-1:0] rd1_e, rd2_e, imm_ext_e;
   logic [AW-1:0] rs1_e, rs2_e, rd_e;
   logic [PW-1:0] pc_e, pc_plus4_e;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   decode_pipe #(.DATA_W(DW), .PC_W(PW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .ctrl_d(ctrl_d), .imm_ext_d(imm_ext_d),
      .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
      .stall_d(stall_d), .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
      .imm_ext_e(imm_ext_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e),
      .pc_plus4_e(pc_plus4_e)
   );

   logic [EW-1:0] w_e;
   assign w_e = {valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e};

   // Reference model: architectural register array and the expected E-stage contents.
   logic [DW-1:0] m_rf [NR];
   logic          m_valid;
   ctrl_t         m_ctrl;
   logic [DW-1:0] m_rd1, m_rd2, m_imm;
   logic [AW-1:0] m_rs1, m_rs2, m_rd;
   logic [PW-1:0] m_pc, m_pc4;

   function automatic logic [32:0] mk_instr(input logic inm, input logic [1:0] tipo,
      input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] f2,
      input logic [12:0] mid, input logic [4:0] low);
      return {inm, tipo, op, rs1, f2, mid, low};
   endfunction

   function automatic ctrl_t mk_ctrl(input logic rw, input logic load);
      ctrl_t c;
      c = '0;
      c.reg_write  = rw;
      c.result_src = load;
      c.alu_ctrl   = 3'b010;
      return c;
   endfunction

   function automatic logic [4:0] f_rs1(input logic [32:0] ins);
      return ins[27:23];
   endfunction

   function automatic logic [4:0] f_rs2(input logic [32:0] ins);
      return ins[32] ? ins[22:18] : ins[4:0];
   endfunction

   function automatic logic [4:0] f_rd(input logic [32:0] ins);
      return (ins[32] || ins[31:28] == 4'b0100) ? ins[22:18] : ins[4:0];
   endfunction

   function automatic logic [DW-1:0] f_read(input logic [4:0] a);
      if (a == 5'd0) return '0;
`ifdef DECODE_WB_BYPASS_EN
      if (reg_write_w && rd_w == a) return result_w;
`endif
      return m_rf[a];
   endfunction

   function automatic logic f_stall();
      logic [4:0] a1, a2;
      a1 = f_rs1(instr_d);
      a2 = f_rs2(instr_d);
      return !rst && valid_d && m_valid && m_ctrl.result_src && m_ctrl.reg_write &&
             m_rd != 0 && (m_rd == a1 || m_rd == a2);
   endfunction

   function automatic logic [EW-1:0] m_vec();
      return {m_valid, m_ctrl, m_rd1, m_rd2, m_imm, m_rs1, m_rs2, m_rd, m_pc, m_pc4};
   endfunction

   task automatic clr_e();
      m_valid = 0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_pc = '0; m_pc4 = '0;
   endtask

   // Advance one clock, updating the model from the inputs present before the edge.
   task automatic cycle();
      logic          st;
      logic [DW-1:0] r1, r2;
      st = f_stall();
      r1 = f_read(f_rs1(instr_d));
      r2 = f_read(f_rs2(instr_d));
      @(posedge clk);
      if (rst) begin
         clr_e();
         for (int i = 0; i < NR; i++) m_rf[i] = '0;
      end else begin
         if (flush_e || st || !valid_d) begin
            clr_e();
         end else begin
            m_valid = 1; m_ctrl = ctrl_d; m_rd1 = r1; m_rd2 = r2; m_imm = imm_ext_d;
            m_rs1 = f_rs1(instr_d); m_rs2 = f_rs2(instr_d); m_rd = f_rd(instr_d);
            m_pc = pc_d; m_pc4 = pc_plus4_d;
         end
         if (reg_write_w && rd_w != 0) m_rf[rd_w] = result_w;
      end
      #1;
   endtask

   task automatic drive_idle();
      rst = 0; valid_d = 0; instr_d = '0; ctrl_d = '0; imm_ext_d = '0;
      pc_d = '0; pc_plus4_d = '0; reg_write_w = 0; rd_w = '0; result_w = '0; flush_e = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1; valid_d = 1; instr_d = 33'h1_2345_6789; ctrl_d = mk_ctrl(1, 1);
      reg_write_w = 1; rd_w = 5'd9; result_w = 18'h0BEEF;
      #1;
      total++;
      if (stall_d !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_d); end
      cycle();
      cycle();
      total++;
      if (w_e !== '0) begin bad++; $display("FAIL reset_outs got=%h exp=0", w_e); end
      rst = 0; reg_write_w = 0;
      instr_d = mk_instr(0, 2'b10, 2'b01, 5'd9, 5'd0, 13'd0, 5'd9);
      #1;
      total++;
      if (stall_d !== 1'b0) begin bad++; $display("FAIL reset_first_stall got=%b exp=0", stall_d); end
      cycle();
      total++;
      if (rd1_e !== '0 || valid_e !== 1'b1) begin
         bad++; $display("FAIL reset_drop_wb got=%h/%b exp=0/1", rd1_e, valid_e);
      end
   endtask

   task automatic test_basic();
      drive_idle();
      reg_write_w = 1; rd_w = 5'd3; result_w = 18'h01234;
      cycle();
      drive_idle();
      valid_d = 1; instr_d = mk_instr(0, 2'b10, 2'b00, 5'd3, 5'd0, 13'h1ABC, 5'd0);
      ctrl_d = mk_ctrl(1, 0); imm_ext_d = 18'h00042; pc_d = 18'h00100; pc_plus4_d = 18'h00104;
      cycle();
      total++;
      if (rd1_e !== 18'h01234 || valid_e !== 1'b1) begin
         bad++; $display("FAIL basic_read got=%h/%b exp=01234/1", rd1_e, valid_e);
      end
      total++;
      if (w_e !== m_vec()) begin bad++; $display("FAIL basic_fields got=%h exp=%h", w_e, m_vec()); end
   endtask

   task automatic test_load_use(input logic do_flush);
      drive_idle();
      cycle();
      valid_d = 1; instr_d = mk_instr(1, 2'b00, 2'b00, 5'd1, 5'd5, 13'd0, 5'd0);
      ctrl_d = mk_ctrl(1, 1);
      cycle();
      instr_d = mk_instr(0, 2'b10, 2'b11, 5'd5, 5'd2, 13'd0, 5'd9);
      ctrl_d = mk_ctrl(1, 0); pc_d = 18'h00200; pc_plus4_d = 18'h00204;
      flush_e = do_flush;
      #1;
      total++;
      if (stall_d !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", stall_d); end
      cycle();
      total++;
      if (w_e !== '0) begin bad++; $display("FAIL load_use_bubble got=%h exp=0", w_e); end
      if (!do_flush) begin
         total++;
         if (stall_d !== 1'b0) begin bad++; $display("FAIL load_use_release got=%b exp=0", stall_d); end
         cycle();
         total++;
         if (valid_e !== 1'b1 || rs1_e !== 5'd5 || rs2_e !== 5'd9 || pc_e !== 18'h00200) begin
            bad++; $display("FAIL load_use_enter got=%b/%h/%h/%h exp=1/05/09/00200",
                            valid_e, rs1_e, rs2_e, pc_e);
         end
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] exp;
      drive_idle();
      reg_write_w = 1; rd_w = 5'd7; result_w = 18'h15555;
      cycle();
      drive_idle();
      valid_d = 1; instr_d = mk_instr(1, 2'b00, 2'b10, 5'd2, 5'd7, 13'd0, 5'd0);
      ctrl_d = mk_ctrl(0, 0);
      reg_write_w = 1; rd_w = 5'd7; result_w = 18'h2AAAA;
      cycle();
`ifdef DECODE_WB_BYPASS_EN
      exp = 18'h2AAAA;
`else
      exp = 18'h15555;
`endif
      total++;
      if (rd2_e !== exp || rs2_e !== 5'd7) begin
         bad++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd2_e, exp);
      end
      reg_write_w = 0;
      cycle();
      total++;
      if (rd2_e !== 18'h2AAAA) begin bad++; $display("FAIL bypass_after got=%h exp=2aaaa", rd2_e); end
   endtask

   task automatic test_r0();
      drive_idle();
      reg_write_w = 1; rd_w = 5'd0; result_w = 18'h3FFFF;
      cycle();
      drive_idle();
      valid_d = 1; instr_d = mk_instr(0, 2'b11, 2'b00, 5'd0, 5'd0, 13'd0, 5'd4);
      ctrl_d = mk_ctrl(1, 0);
      cycle();
      total++;
      if (rd1_e !== '0) begin bad++; $display("FAIL r0_read got=%h exp=0", rd1_e); end
      instr_d = mk_instr(1, 2'b00, 2'b00, 5'd1, 5'd0, 13'd0, 5'd0);
      ctrl_d = mk_ctrl(1, 1);
      cycle();
      instr_d = mk_instr(0, 2'b11, 2'b00, 5'd0, 5'd0, 13'd0, 5'd0);
      ctrl_d = mk_ctrl(1, 0);
      #1;
      total++;
      if (stall_d !== 1'b0) begin bad++; $display("FAIL r0_no_stall got=%b exp=0", stall_d); end
      cycle();
      total++;
      if (valid_e !== 1'b1) begin bad++; $display("FAIL r0_flow got=%b exp=1", valid_e); end
   endtask

   task automatic test_reset_mid();
      drive_idle();
      valid_d = 1; instr_d = mk_instr(1, 2'b00, 2'b00, 5'd1, 5'd6, 13'd0, 5'd0);
      ctrl_d = mk_ctrl(1, 1); pc_d = 18'h00300;
      cycle();
      total++;
      if (valid_e !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b exp=1", valid_e); end
      instr_d = mk_instr(0, 2'b10, 2'b00, 5'd6, 5'd0, 13'd0, 5'd6);
      ctrl_d = mk_ctrl(1, 0);
      rst = 1;
      #1;
      total++;
      if (stall_d !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", stall_d); end
      cycle();
      total++;
      if (w_e !== '0 || stall_d !== 1'b0) begin
         bad++; $display("FAIL rst_mid_outs got=%h/%b exp=0/0", w_e, stall_d);
      end
      rst = 0;
      cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst         = ($urandom_range(99) == 0);
         valid_d     = ($urandom_range(3) != 0);
         instr_d     = mk_instr(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
                                5'($urandom_range(7)), 5'($urandom_range(7)), 13'($urandom()),
                                5'($urandom_range(7)));
         ctrl_d      = ctrl_t'(10'($urandom()));
         imm_ext_d   = 18'($urandom());
         pc_d        = 18'($urandom());
         pc_plus4_d  = pc_d + 18'd4;
         flush_e     = ($urandom_range(9) == 0);
         reg_write_w = 1'($urandom_range(1));
         rd_w        = 5'($urandom_range(7));
         result_w    = 18'($urandom());
         #1;
         total++;
         if (stall_d !== f_stall()) begin
            bad++; $display("FAIL rand_stall n=%0d got=%b exp=%b", n, stall_d, f_stall());
         end
         cycle();
         total++;
         if (w_e !== m_vec()) begin
            bad++; $display("FAIL rand_e n=%0d got=%h exp=%h", n, w_e, m_vec());
         end
      end
   endtask

   initial begin
      clr_e();
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      drive_idle();
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_load_use(1'b0);
      test_load_use(1'b1);
      test_bypass();
      test_r0();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning register and immediate data width.
REQ-002 SHALL have parameter PC_W, default 18, meaning PC and PC+4 width.
REQ-003 SHALL have parameter NUM_REGS, default 32, meaning register count; ADDR_W = clog2(NUM_REGS), max 5.
REQ-004 SHALL have ports: clk  in  1  clock, single clock domain; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: instr_d  in  33  D instruction; valid_d  in  1  D instruction valid; pc_d, pc_plus4_d  in  PC_W  D PCs.
REQ-006 SHALL have ports: ctrl_d  in  ctrl_t  control bundle from control unit; imm_ext_d  in  DATA_W  extended immediate.
REQ-007 SHALL have ports: reg_write_w  in  1; rd_w  in  ADDR_W; result_w  in  DATA_W  writeback.
REQ-008 SHALL have ports: flush_e  in  1  kill instruction entering E; stall_d  out  1  load-use stall to fetch/D.
REQ-009 SHALL have ports: valid_e  out  1; ctrl_e  out  ctrl_t; rd1_e, rd2_e, imm_ext_e  out  DATA_W; rs1_e, rs2_e, rd_e  out  ADDR_W; pc_e, pc_plus4_e  out  PC_W.

Function
REQ-010 SHALL decode rs1 = instr_d[27:23]; rs2 = instr_d[22:18] when instr_d[32]=1, else instr_d[4:0].
REQ-011 SHALL decode rd = instr_d[22:18] when (instr_d[31:30]=01 and instr_d[29:28]=00) or instr_d[32]=1, else instr_d[4:0].
REQ-012 SHALL read rd1/rd2 combinationally from register file at rs1/rs2; register 0 reads 0 and ignores writes.
REQ-013 SHALL write result_w to rd_w on clk edge when reg_write_w=1 and rd_w!=0.
REQ-014 SHALL assert stall_d combinationally when valid_d, valid_e, ctrl_e.result_src, ctrl_e.reg_write, rd_e!=0 and rd_e equals rs1 or rs2.
REQ-015 SHALL load E register from D each cycle with latency one: valid_e<=valid_d, all fields captured.
REQ-016 SHALL load a bubble (valid_e=0, ctrl_e all zero, data fields zero) when flush_e=1 or stall_d=1.
REQ-017 SHALL apply precedence rst > flush_e > stall_d bubble > normal load.
REQ-018 SHALL hold stall_d for exactly one cycle per load-use hazard, since the bubble clears the condition.
REQ-019 SHALL treat valid_d=0 as a bubble: valid_e=0, ctrl_e zero, no stall.
REQ-020 SHALL output rs2_e as the actual read index from REQ-010.

Reset
REQ-021 SHALL on rst=1 at clk edge clear valid_e, ctrl_e, rd1_e, rd2_e, imm_ext_e, rs1_e, rs2_e, rd_e, pc_e, pc_plus4_e to 0.
REQ-022 SHALL clear all register-file entries to 0 on reset; writeback in the reset cycle SHALL be dropped.
REQ-023 SHALL hold stall_d=0 while rst=1 and on the first cycle after it, since valid_e=0.

Configuration
REQ-024 SHALL, with DECODE_WB_BYPASS_EN defined, forward result_w to rd1/rd2 when reg_write_w=1, rd_w!=0 and rd_w matches rs1/rs2 in the same cycle.
REQ-025 SHALL, without DECODE_WB_BYPASS_EN, return the pre-write register value in that cycle.

Structure
REQ-026 SHALL place ctrl_t (reg_write, alu_src, mem_write, result_src, branch, alu_ctrl[2:0], rgb[1:0]) in package decode_pkg.
REQ-027 SHALL place instruction field-position constants (INM_BIT, TIPO, OP, RS1, RS2/RD fields) and INSTR_W=33 in decode_pkg.
REQ-028 SHALL instantiate one sub-module decode_regfile (NUM_REGS x DATA_W, 2 read, 1 write, optional bypass).

Verification
REQ-029 SHALL cover: reset, write r3=0x1234, then D reads rs1=3 -> rd1_e=0x1234 one cycle later, valid_e=1.
REQ-030 SHALL cover: load with rd_e=5 in E, D rs1=5 -> stall_d=1 one cycle, valid_e=0 next, same D instruction enters E after.
REQ-031 SHALL cover: flush_e=1 with stall_d=1 -> bubble loaded, valid_e=0, ctrl_e=0.
REQ-032 SHALL cover: same-cycle write r7=0x2AAAA and read rs2=7 -> rd2_e=0x2AAAA with DECODE_WB_BYPASS_EN, old value without.
REQ-033 SHALL cover: write to r0 value 0x3FFFF, then read rs1=0 -> rd1_e=0; load to rd_e=0 -> no stall.
REQ-034 SHALL cover: rst asserted mid-stream with valid_e=1 -> all outputs 0 next cycle, stall_d=0.
